// File: rtl/rot_seq_pkg.sv
// Shared types and constants for the sequential single-bit rotate controller.
package rot_seq_pkg;

    localparam int ROT_WIDTH_DEFAULT = 8;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } rot_state_e;

endpackage

// File: rtl/rot_step.sv
// Combinational one-bit rotator: left wraps MSB into LSB, right wraps LSB into MSB.
module rot_step
    import rot_seq_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = (dir_i == ROT_RIGHT) ? {data_i[0], data_i[WIDTH-1:1]}
                                         : {data_i[WIDTH-2:0], data_i[WIDTH-1]};

endmodule

// File: rtl/rot_seq_ctrl.sv
// Multi-bit rotate sequenced as one single-bit step per clock, one request in flight.
// Define ROT_SEQ_SHORTPATH_EN to rotate the shorter way round for amounts above WIDTH/2.
module rot_seq_ctrl
    import rot_seq_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH_DEFAULT,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_data_i,
    input  logic             req_dir_i,
    input  logic [AMT_W-1:0] req_amt_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             busy_o
);

    rot_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] acc_amt;
    logic             acc_dir;

    rot_step #(.WIDTH(WIDTH)) u_step (
        .data_i (data_q),
        .dir_i  (dir_q),
        .data_o (step_data)
    );

`ifdef ROT_SEQ_SHORTPATH_EN
    localparam logic [AMT_W:0] WIDTH_L = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W:0] HALF_L  = (AMT_W+1)'(WIDTH / 2);

    // Rotating left by k equals rotating right by WIDTH-k, so pick the shorter way.
    always_comb begin
        acc_amt = req_amt_i;
        acc_dir = req_dir_i;
        if ({1'b0, req_amt_i} > HALF_L) begin
            acc_amt = AMT_W'(WIDTH_L - {1'b0, req_amt_i});
            acc_dir = ~req_dir_i;
        end
    end
`else
    always_comb begin
        acc_amt = req_amt_i;
        acc_dir = req_dir_i;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= ROT_LEFT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    dir_d   = acc_dir;
                    cnt_d   = acc_amt;
                    state_d = (acc_amt == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                data_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready depends on state only, so a response hand-off never overlaps a new accept.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == DONE);
        rsp_data_o  = (state_q == DONE) ? data_q : '0;
        busy_o      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Randomized check of rot_seq_ctrl against an arithmetic rotate/latency reference model.
module tb_rot_seq_ctrl;

    localparam int W     = 8;
    localparam int AMT_W = $clog2(W);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [W-1:0]     req_data = '0;
    logic             req_dir = 1'b0;
    logic [AMT_W-1:0] req_amt = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [W-1:0]     rsp_data;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    rot_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_dir_i   (req_dir),
        .req_amt_i   (req_amt),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Right by k is left by W-k; left by s is the top half of {d,d} << s.
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input logic dir, input int k);
        logic [2*W-1:0] t;
        int s;
        s = dir ? (W - k) % W : k;
        t = {d, d} << s;
        return t[2*W-1:W];
    endfunction

    function automatic int ref_lat(input int amt);
        int steps;
        steps = amt;
`ifdef ROT_SEQ_SHORTPATH_EN
        if (amt > W / 2) steps = W - amt;
`endif
        return steps + 1;
    endfunction

    task automatic do_req(input logic [W-1:0] d, input logic dir, input int amt,
                          input int hold, input bit rival);
        int lat;
        logic [W-1:0] exp;
        exp = ref_rot(d, dir, amt);
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_data  = d;
        req_dir   = dir;
        req_amt   = AMT_W'(amt);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            req_data  = W'($urandom);
            req_dir   = 1'($urandom);
            req_amt   = AMT_W'($urandom);
            if (!rsp_valid) begin
                chk("busy_rot", 32'(busy), 1);
                chk("ready_rot", 32'(req_ready), 0);
            end
        end while (!rsp_valid && lat < 64);
        chk("latency", 32'(lat), 32'(ref_lat(amt)));
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("ready_done", 32'(req_ready), 0);
        chk("busy_done", 32'(busy), 1);
        repeat (hold) begin
            if (rival) begin
                req_valid = 1'b1;
                req_data  = ~d;
                req_amt   = AMT_W'($urandom);
            end
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(exp));
            chk("hold_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("drop_valid", 32'(rsp_valid), 0);
        chk("back_idle", 32'(req_ready), 1);
        chk("busy_idle", 32'(busy), 0);
        if (rival) begin
            @(negedge clk);
            chk("rival_ignored", 32'({busy, rsp_valid}), 0);
        end
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        do_req(8'h81, 1'b0, 1, 0, 1'b0);
        do_req(8'h81, 1'b1, 1, 0, 1'b0);
        do_req(8'hA5, 1'b0, 4, 0, 1'b0);
        do_req(8'h3C, 1'b0, 0, 1, 1'b0);
        do_req(8'h5B, 1'b1, 3, 3, 1'b1);
        do_req(8'h01, 1'b0, 7, 0, 1'b0);
        do_req(8'h80, 1'b1, 7, 0, 1'b0);
        do_req(8'h96, 1'b1, 4, 0, 1'b0);

        // Abort mid-rotation with an asynchronous reset.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'hF0;
        req_dir   = 1'b0;
        req_amt   = AMT_W'(6);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_valid", 32'(rsp_valid), 0);
        chk("abort_data", 32'(rsp_data), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        do_req(8'h01, 1'b0, 2, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_req(W'($urandom), 1'($urandom), int'($urandom_range(0, W - 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
